// File: rtl/driver_cmd_decoder.sv
// Passive decoder for a serial LED-driver command bus: samples SCLK/LAT/SIN,
// counts LAT-high SCLK edges per command and tracks FC and grayscale state.
module driver_cmd_decoder #(
  parameter int WORD_BITS   = 48,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_33,
  input  logic                 nrst,
  input  logic                 sclk,
  input  logic                 lat,
  input  logic                 sin,
  input  logic                 clear_err,
  output logic                 cmd_valid,
  output logic [3:0]           cmd_code,
  output logic [WORD_BITS-1:0] cmd_data,
  output logic                 cmd_err,
  output logic [WORD_BITS-1:0] fc_reg,
  output logic                 fc_wr,
  output logic                 fc_wr_en,
  output logic [3:0]           gs_count,
  output logic                 latgs_pulse,
  output logic [4:0]           gs_words,
  output logic                 word_err
);

  localparam logic [3:0] CMD_WRTGS     = 4'd1;
  localparam logic [3:0] CMD_LATGS     = 4'd3;
  localparam logic [3:0] CMD_WRTFC     = 4'd5;
  localparam logic [3:0] CMD_LINERESET = 4'd7;
  localparam logic [3:0] CMD_READFC    = 4'd11;
  localparam logic [3:0] CMD_TMGRST    = 4'd13;
  localparam logic [3:0] CMD_FCWRTEN   = 4'd15;
  localparam logic [6:0] WORD_BITS_7   = 7'(WORD_BITS);

  function automatic logic [6:0] sat_inc7(input logic [6:0] v);
    return (v == 7'h7f) ? v : v + 7'd1;
  endfunction

  function automatic logic [4:0] sat_inc5(input logic [4:0] v);
    return (v == 5'h1f) ? v : v + 5'd1;
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hf) ? v : v + 4'd1;
  endfunction

  function automatic logic is_known_cmd(input logic [4:0] n);
    case (n)
      5'd1, 5'd3, 5'd5, 5'd7, 5'd11, 5'd13, 5'd15: return 1'b1;
      default:                                     return 1'b0;
    endcase
  endfunction

  logic [SYNC_STAGES-1:0] sclk_sync, lat_sync, sin_sync;
  logic                   sclk_p0, lat_p0, sin_p0;
  logic                   sclk_p1, lat_p1;
  logic [WORD_BITS-1:0]   shift_reg;
  logic [6:0]             bit_cnt;
  logic [4:0]             lat_cnt;

  logic                   sclk_rise, lat_fall;
  logic [WORD_BITS-1:0]   shift_nx;
  logic [6:0]             bit_nx;
  logic [4:0]             lat_nx;
  logic                   word_ok;

  // Stage p0: synchronised copies; p1: previous value for edge detection
  assign sclk_p0 = sclk_sync[SYNC_STAGES-1];
  assign lat_p0  = lat_sync[SYNC_STAGES-1];
  assign sin_p0  = sin_sync[SYNC_STAGES-1];

  assign sclk_rise = sclk_p0 & ~sclk_p1;
  assign lat_fall  = ~lat_p0 & lat_p1;

  // A bit arriving on the same cycle as the LAT fall is folded into the snapshot.
  always_comb begin
    shift_nx = shift_reg;
    bit_nx   = bit_cnt;
    lat_nx   = lat_cnt;
    if (sclk_rise) begin
      shift_nx = {shift_reg[WORD_BITS-2:0], sin_p0};
      bit_nx   = sat_inc7(bit_cnt);
      if (lat_p0)
        lat_nx = sat_inc5(lat_cnt);
    end
  end

  assign word_ok = (bit_nx == WORD_BITS_7);

  always_ff @(posedge clk_33 or negedge nrst) begin
    if (!nrst) begin
      sclk_sync   <= '0;
      lat_sync    <= '0;
      sin_sync    <= '0;
      sclk_p1     <= 1'b0;
      lat_p1      <= 1'b0;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      lat_cnt     <= '0;
      cmd_valid   <= 1'b0;
      cmd_code    <= '0;
      cmd_data    <= '0;
      cmd_err     <= 1'b0;
      fc_reg      <= '0;
      fc_wr       <= 1'b0;
      fc_wr_en    <= 1'b0;
      gs_count    <= '0;
      latgs_pulse <= 1'b0;
      gs_words    <= '0;
      word_err    <= 1'b0;
    end else begin
      sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      lat_sync    <= {lat_sync[SYNC_STAGES-2:0], lat};
      sin_sync    <= {sin_sync[SYNC_STAGES-2:0], sin};
      sclk_p1     <= sclk_p0;
      lat_p1      <= lat_p0;
      shift_reg   <= shift_nx;
      cmd_valid   <= 1'b0;
      cmd_err     <= 1'b0;
      fc_wr       <= 1'b0;
      latgs_pulse <= 1'b0;
      if (clear_err)
        word_err <= 1'b0;

      // Stage p2: command decode on LAT fall, results visible next cycle
      if (lat_fall) begin
        bit_cnt   <= '0;
        lat_cnt   <= '0;
        cmd_valid <= 1'b1;
        cmd_data  <= shift_nx;
        if (is_known_cmd(lat_nx)) begin
          cmd_code <= lat_nx[3:0];
          fc_wr_en <= 1'b0;
          case (lat_nx[3:0])
            CMD_WRTGS: begin
              gs_count <= sat_inc4(gs_count);
              if (!word_ok)
                word_err <= 1'b1;
            end
            CMD_LATGS, CMD_LINERESET: begin
              latgs_pulse <= 1'b1;
              gs_words    <= {1'b0, gs_count} + 5'd1;
              gs_count    <= '0;
              if (!word_ok && lat_nx[3:0] == CMD_LATGS)
                word_err <= 1'b1;
            end
            CMD_WRTFC: begin
              if (fc_wr_en) begin
                fc_reg <= shift_nx;
                fc_wr  <= 1'b1;
              end
              if (!word_ok)
                word_err <= 1'b1;
            end
            CMD_TMGRST:  gs_count <= '0;
            CMD_FCWRTEN: fc_wr_en <= 1'b1;
            CMD_READFC:  ;
            default:     ;
          endcase
        end else begin
          cmd_code <= '0;
          cmd_err  <= 1'b1;
        end
      end else begin
        bit_cnt <= bit_nx;
        lat_cnt <= lat_nx;
      end
    end
  end

endmodule

// File: tb/tb_driver_cmd_decoder.sv
// Directed bench for driver_cmd_decoder: a reference model pushes expected
// decode results into a queue that a monitor pops on every cmd_valid.
module tb_driver_cmd_decoder;

  logic        clk_33 = 1'b0;
  logic        nrst = 1'b0;
  logic        sclk = 1'b0;
  logic        lat = 1'b0;
  logic        sin = 1'b0;
  logic        clear_err = 1'b0;
  logic        cmd_valid;
  logic [3:0]  cmd_code;
  logic [47:0] cmd_data;
  logic        cmd_err;
  logic [47:0] fc_reg;
  logic        fc_wr;
  logic        fc_wr_en;
  logic [3:0]  gs_count;
  logic        latgs_pulse;
  logic [4:0]  gs_words;
  logic        word_err;

  driver_cmd_decoder #(.WORD_BITS(48), .SYNC_STAGES(2)) dut (
    .clk_33(clk_33), .nrst(nrst), .sclk(sclk), .lat(lat), .sin(sin),
    .clear_err(clear_err), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .cmd_data(cmd_data), .cmd_err(cmd_err), .fc_reg(fc_reg), .fc_wr(fc_wr),
    .fc_wr_en(fc_wr_en), .gs_count(gs_count), .latgs_pulse(latgs_pulse),
    .gs_words(gs_words), .word_err(word_err)
  );

  always #15 clk_33 = ~clk_33;

  typedef struct {
    logic [3:0]  code;
    logic        err;
    logic        fcw;
    logic        lgs;
    logic        wen;
    logic        werr;
    logic [3:0]  gsc;
    logic [4:0]  gsw;
    logic [47:0] fcr;
    logic [47:0] data;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_err = 0;

  logic [47:0] m_sr = '0;
  logic [47:0] m_fcr = '0;
  logic        m_wen = 1'b0;
  logic        m_werr = 1'b0;
  logic [3:0]  m_gsc = '0;
  logic [4:0]  m_gsw = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk_33);
  endtask

  task automatic send_bit(input logic b, input logic l);
    @(posedge clk_33);
    #1 sin = b; lat = l;
    clks(2);
    #1 sclk = 1'b1;
    clks(4);
    #1 sclk = 1'b0;
    clks(2);
    m_sr = {m_sr[46:0], b};
  endtask

  task automatic model_reset();
    m_sr = '0; m_fcr = '0; m_wen = 1'b0; m_werr = 1'b0; m_gsc = '0; m_gsw = '0;
  endtask

  task automatic send_cmd(input int nbits, input logic [47:0] data, input int nlat);
    exp_t e;
    logic valid;
    logic [3:0] code;
    for (int i = 0; i < nbits; i++)
      send_bit(data[nbits-1-i], (i >= nbits - nlat));
    valid = (nlat == 1 || nlat == 3 || nlat == 5 || nlat == 7 ||
             nlat == 11 || nlat == 13 || nlat == 15);
    code  = valid ? 4'(nlat) : 4'd0;
    e.code = code; e.err = !valid; e.fcw = 1'b0; e.lgs = 1'b0; e.data = m_sr;
    if (valid) begin
      if ((code == 4'd1 || code == 4'd3 || code == 4'd5) && nbits != 48)
        m_werr = 1'b1;
      case (code)
        4'd1: if (m_gsc != 4'hf) m_gsc = m_gsc + 4'd1;
        4'd3, 4'd7: begin e.lgs = 1'b1; m_gsw = {1'b0, m_gsc} + 5'd1; m_gsc = '0; end
        4'd5: if (m_wen) begin m_fcr = m_sr; e.fcw = 1'b1; end
        4'd13: m_gsc = '0;
        default: ;
      endcase
      m_wen = (code == 4'd15);
    end
    e.wen = m_wen; e.werr = m_werr; e.gsc = m_gsc; e.gsw = m_gsw; e.fcr = m_fcr;
    sb.push_back(e);
    @(posedge clk_33);
    #1 lat = 1'b0;
    clks(8);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({cmd_valid, cmd_code, cmd_err, fc_wr, fc_wr_en, gs_count,
                latgs_pulse, gs_words, word_err}) | 64'(cmd_data) | 64'(fc_reg);
  endfunction

  always @(negedge clk_33) begin
    if (nrst && cmd_valid) begin
      n_checks++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_cmd_valid observed=1 expected=0");
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("cmd_code", 64'(cmd_code), 64'(e.code));
        check("cmd_err", 64'(cmd_err), 64'(e.err));
        check("cmd_data", 64'(cmd_data), 64'(e.data));
        check("fc_wr", 64'(fc_wr), 64'(e.fcw));
        check("fc_reg", 64'(fc_reg), 64'(e.fcr));
        check("fc_wr_en", 64'(fc_wr_en), 64'(e.wen));
        check("latgs_pulse", 64'(latgs_pulse), 64'(e.lgs));
        check("gs_count", 64'(gs_count), 64'(e.gsc));
        check("gs_words", 64'(gs_words), 64'(e.gsw));
        check("word_err", 64'(word_err), 64'(e.werr));
      end
    end else if (nrst) begin
      check("stray_pulse", 64'({cmd_err, fc_wr, latgs_pulse}), 64'(0));
    end
  end

  initial begin
    clks(3);
    @(negedge clk_33);
    check("reset_outputs", all_outs(), 64'(0));
    @(posedge clk_33);
    #1 nrst = 1'b1;
    clks(4);

    // FCWRTEN then WRTFC loads fc_reg
    send_cmd(15, 48'h0000_0000_5A5A, 15);
    send_cmd(48, 48'hA5A5_0000_FFFF, 5);
    // WRTFC without enable leaves fc_reg alone
    send_cmd(48, 48'h1234_5678_9ABC, 5);

    for (int k = 0; k < 7; k++)
      send_cmd(48, 48'({$urandom, $urandom}), 1);
    send_cmd(48, 48'({$urandom, $urandom}), 3);

    // Unknown LAT counts, including one whose low nibble aliases WRTGS
    send_cmd(9, 48'h1FF, 9);
    send_cmd(17, 48'h1_5555, 17);

    send_cmd(15, 48'h7FFF, 15);
    send_cmd(11, 48'h3C3, 11);
    send_cmd(48, 48'h0F0F_0F0F_0F0F, 1);
    send_cmd(48, 48'hF0F0_F0F0_F0F0, 1);
    send_cmd(13, 48'h1ABC, 13);
    send_cmd(48, 48'h0123_4567_89AB, 1);
    send_cmd(7, 48'h55, 7);

    // Short word raises sticky word_err until cleared
    send_cmd(40, 48'h00AB_CDEF_0123, 1);
    send_cmd(48, 48'hCAFE_F00D_BEEF, 1);
    @(posedge clk_33);
    #1 clear_err = 1'b1;
    @(posedge clk_33);
    #1 clear_err = 1'b0;
    m_werr = 1'b0;
    @(negedge clk_33);
    check("word_err_cleared", 64'(word_err), 64'(m_werr));

    // Reset in the middle of a word
    for (int i = 0; i < 20; i++)
      send_bit(1'($urandom), 1'b0);
    @(negedge clk_33);
    nrst = 1'b0;
    #1;
    check("async_reset_outputs", all_outs(), 64'(0));
    model_reset();
    clks(3);
    @(negedge clk_33);
    check("held_reset_outputs", all_outs(), 64'(0));
    @(posedge clk_33);
    #1 nrst = 1'b1;
    clks(4);
    send_cmd(48, 48'h8000_0000_0001, 1);

    for (int i = 0; i < 200 && sb.size() != 0; i++)
      @(posedge clk_33);
    check("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/driver_cmd_decoder.md
DRIVER_CMD_DECODER -- requirements
Module: driver_cmd_decoder

Interface
REQ-001 SHALL have parameter WORD_BITS, default 48, the serial word length per command.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the synchroniser depth on sclk/lat/sin (minimum 2).
REQ-003 SHALL have port clk_33  input  1  system clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port sclk  input  1  monitored driver SCLK; asynchronous; frequency at most clk_33/4.
REQ-006 SHALL have port lat  input  1  monitored driver LAT; asynchronous.
REQ-007 SHALL have port sin  input  1  monitored driver SIN, one lane; asynchronous.
REQ-008 SHALL have port clear_err  input  1  synchronous clear of word_err.
REQ-009 SHALL have port cmd_valid  output  1  one-cycle pulse, command decoded.
REQ-010 SHALL have port cmd_code  output  4  LAT edge count of the last command; 0 = invalid.
REQ-011 SHALL have port cmd_data  output  WORD_BITS  shift register snapshot at decode.
REQ-012 SHALL have port cmd_err  output  1  one-cycle pulse, unknown LAT count.
REQ-013 SHALL have port fc_reg  output  WORD_BITS  decoded function-control register.
REQ-014 SHALL have port fc_wr  output  1  one-cycle pulse, fc_reg updated.
REQ-015 SHALL have port fc_wr_en  output  1  FC write enable flag (set by FCWRTEN).
REQ-016 SHALL have port gs_count  output  4  WRTGS words received since the last latch.
REQ-017 SHALL have port latgs_pulse  output  1  one-cycle pulse, LATGS decoded.
REQ-018 SHALL have port gs_words  output  5  gs_count+1, captured at LATGS.
REQ-019 SHALL have port word_err  output  1  sticky flag, data command with bit count not equal to WORD_BITS.

Function
REQ-020 SHALL synchronise sclk, lat and sin through SYNC_STAGES flops (reset 0); all logic uses the synchronised copies.
REQ-021 SHALL detect an SCLK rise as synced sclk 1 while its previous value was 0, and a LAT fall the same way (1 to 0).
REQ-022 On each SCLK rise: SHALL shift the synced sin into the LSB of a WORD_BITS register (MSB first out), increment bit_cnt (7b, saturating at 127), and, if synced lat=1 in that cycle, increment lat_cnt (5b, saturating at 31).
REQ-023 On a LAT fall: SHALL decode lat_cnt. The decode table is 1 WRTGS, 3 LATGS, 5 WRTFC, 7 LINERESET, 11 READFC, 13 TMGRST, 15 FCWRTEN.
REQ-024 The decode outputs SHALL register on the cycle after the LAT fall: cmd_valid=1, cmd_code=lat_cnt[3:0] if the count is in the table else 0, cmd_data=shift register.
REQ-025 On any count not in the table (including 0 or above 15): SHALL set cmd_code=0, pulse cmd_err with cmd_valid, and change no other state.
REQ-026 SHALL clear lat_cnt and bit_cnt on the same cycle as the decode; the shift register is not cleared.
REQ-027 On a simultaneous SCLK rise and LAT fall: SHALL shift the bit (not counted as a LAT edge) before the decode snapshot.
REQ-028 FCWRTEN SHALL set fc_wr_en.
REQ-029 WRTFC with fc_wr_en=1 SHALL load fc_reg, pulse fc_wr, and clear fc_wr_en.
REQ-030 WRTFC with fc_wr_en=0 SHALL leave fc_reg unchanged with no fc_wr, and SHALL still assert cmd_valid.
REQ-031 Any other valid command SHALL clear fc_wr_en.
REQ-032 WRTGS SHALL increment gs_count, saturating at 15.
REQ-033 LATGS SHALL pulse latgs_pulse, set gs_words=gs_count+1, and clear gs_count.
REQ-034 LINERESET SHALL do the same as LATGS.
REQ-035 TMGRST SHALL clear gs_count only.
REQ-036 READFC SHALL have no side effect.
REQ-037 For WRTGS, LATGS and WRTFC with bit_cnt not equal to WORD_BITS: SHALL set word_err; word_err stays set until clear_err=1, which clears it.
REQ-038 If a set and clear_err happen in the same cycle, the set SHALL win.
REQ-039 The pulse outputs (cmd_valid, cmd_err, fc_wr, latgs_pulse) SHALL be high for exactly 1 clk_33 cycle per decode.

Reset
REQ-040 When nrst=0: all flops, counters, fc_reg, fc_wr_en, gs_count, gs_words, word_err and all pulse outputs SHALL be 0 immediately (asynchronous).
REQ-041 When nrst=0: cmd_code and cmd_data SHALL be 0.
REQ-042 A reset during a word SHALL discard the partial word; the first LAT fall after reset decodes only the edges seen after reset.
REQ-043 Release of nrst SHALL be synchronous to clk_33 (external reset synchroniser); the SCLK rise and LAT fall detectors SHALL see no edge on the first cycle after release.

Verification
REQ-044 FCWRTEN, then a 48-bit word 0xA5A5_0000_FFFF with lat high on the last 5 SCLK: cmd_code 15 then 5, fc_wr pulse, fc_reg=0xA5A5_0000_FFFF, fc_wr_en=0.
REQ-045 WRTFC without a prior FCWRTEN: cmd_valid with cmd_code=5, fc_reg unchanged, no fc_wr.
REQ-046 Eight 48-bit words, the first seven with WRTGS (lat on the last SCLK) and the eighth with LATGS (lat on the last 3 SCLK): gs_count steps 1..7 then 0, latgs_pulse once, gs_words=8.
REQ-047 lat high for 9 SCLK edges: cmd_err pulse, cmd_code=0, gs_count and fc_reg unchanged.
REQ-048 WRTGS after 40 bits: word_err=1, held until clear_err pulse, then 0.
REQ-049 nrst asserted mid-word after 20 bits, then a full 48-bit WRTGS: all outputs 0 during reset, then one valid WRTGS decode with gs_count=1 and word_err=0.
